// File: rtl/count_cmd_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module  : count_ctrl_pkg
// Brief   : Shared types, constants and arbitration helper for the count
//           command scheduler.
// Rev     : 1.0  initial release
// ============================================================================
package count_ctrl_pkg;

    localparam int NUM_REQ = 4;

    typedef enum logic [1:0] {
        OP_INC = 2'b00,
        OP_DEC = 2'b01,
        OP_ADD = 2'b10,
        OP_SUB = 2'b11
    } op_e;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } state_e;

    // Returns the first pending requester found scanning upward from start (mod 4).
    // Descending loop: the last hit written is the one closest to start.
    function automatic logic [1:0] pick_winner(input logic [NUM_REQ-1:0] pend,
                                               input logic [1:0]         start);
        logic [1:0] idx;
        logic [1:0] win;
        win = 2'd0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = start + 2'(k);
            if (pend[idx]) begin
                win = idx;
            end
        end
        return win;
    endfunction

endpackage
`default_nettype wire

// File: rtl/count_cmd_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module  : count_cmd_scheduler_if
// Brief   : Valid/ready command channel from the scheduler to the counter
//           datapath.
// Rev     : 1.0  initial release
// ============================================================================
interface count_cmd_scheduler_if
    import count_ctrl_pkg::*;
    #(parameter int WIDTH = 16);

    logic             op_valid;
    op_e              op_code;
    logic [WIDTH-1:0] op_operand;
    logic             op_ready;

    modport master (output op_valid, output op_code, output op_operand, input  op_ready);
    modport slave  (input  op_valid, input  op_code, input  op_operand, output op_ready);

endinterface
`default_nettype wire

// File: rtl/count_cmd_scheduler_req_edge_capture.sv
`default_nettype none
// ============================================================================
// Module  : req_edge_capture
// Brief   : Per-requester rising-edge detect, pending flag, operand capture
//           and drop pulse (first press wins while pending).
// Rev     : 1.0  initial release
// ============================================================================
module req_edge_capture #(
    parameter int WIDTH   = 16,
    parameter bit CAPTURE = 1'b0
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             req,
    input  wire logic [WIDTH-1:0] sw,
    input  wire logic             clear,
    output logic                  pending,
    output logic [WIDTH-1:0]      opnd,
    output logic                  drop
);

    logic             r_req_d;
    logic             r_pending;
    logic [WIDTH-1:0] r_opnd;
    logic             w_rise;
    logic             w_take;

    assign w_rise = req & ~r_req_d;
    // A rise coinciding with the grant's accept re-arms instead of dropping.
    assign w_take = w_rise & (~r_pending | clear);
    assign drop   = w_rise & r_pending & ~clear;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_req_d   <= 1'b0;
            r_pending <= 1'b0;
            r_opnd    <= '0;
        end else begin
            r_req_d <= req;
            if (w_rise) begin
                r_pending <= 1'b1;
            end else if (clear) begin
                r_pending <= 1'b0;
            end
            if (CAPTURE && w_take) begin
                r_opnd <= sw;
            end
        end
    end

    assign pending = r_pending;
    assign opnd    = r_opnd;

endmodule
`default_nettype wire

// File: rtl/count_cmd_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : count_cmd_scheduler
// Brief   : Latches button commands and issues them one at a time to the
//           counter datapath over a valid/ready channel.
// Options : ROUND_ROBIN_EN - rotating-priority arbitration (default: fixed
//           priority INC > DEC > ADD > SUB)
// Rev     : 1.0  initial release
// ============================================================================
module count_cmd_scheduler
    import count_ctrl_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DROP_W = 8
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    input  wire logic [NUM_REQ-1:0] req,
    input  wire logic [WIDTH-1:0]   sw,
    count_cmd_scheduler_if.master   op,
    output logic                    busy,
    output logic [NUM_REQ-1:0]      pending,
    output logic [DROP_W-1:0]       drop_count
);

    localparam int c_SUM_W  = $clog2(NUM_REQ + 1);
    localparam int c_DROP_X = DROP_W + 1;

    logic [NUM_REQ-1:0] w_pending;
    logic [NUM_REQ-1:0] w_drop;
    logic [NUM_REQ-1:0] w_clear;
    logic [WIDTH-1:0]   w_opnd [NUM_REQ];
    logic               w_accept;
    logic [1:0]         w_start;
    logic [1:0]         w_winner;
    logic [WIDTH-1:0]   w_issue_operand;
    logic [c_SUM_W-1:0] w_drop_sum;
    logic [DROP_W:0]    w_drop_ext;

    state_e             r_state;
    logic               r_valid;
    op_e                r_code;
    logic [1:0]         r_grant;
    logic [WIDTH-1:0]   r_operand;
    logic [DROP_W-1:0]  r_drop_count;

    generate
        for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
            req_edge_capture #(
                .WIDTH   (WIDTH),
                .CAPTURE (i >= 2)
            ) u_cap (
                .clk     (clk),
                .rst_n   (rst_n),
                .req     (req[i]),
                .sw      (sw),
                .clear   (w_clear[i]),
                .pending (w_pending[i]),
                .opnd    (w_opnd[i]),
                .drop    (w_drop[i])
            );
        end
    endgenerate

    assign w_accept = (r_state == S_ISSUE) & r_valid & op.op_ready;

    always_comb begin
        w_clear = '0;
        if (w_accept) begin
            w_clear[r_grant] = 1'b1;
        end
    end

`ifdef ROUND_ROBIN_EN
    logic [1:0] r_rp;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rp <= 2'd0;
        end else if (w_accept) begin
            r_rp <= r_grant + 2'd1;
        end
    end

    assign w_start = r_rp;
`else
    assign w_start = 2'd0;
`endif

    assign w_winner        = pick_winner(w_pending, w_start);
    assign w_issue_operand = (w_winner[1] == 1'b0) ? {{(WIDTH-1){1'b0}}, 1'b1}
                                                   : w_opnd[w_winner];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_valid   <= 1'b0;
            r_code    <= OP_INC;
            r_grant   <= 2'd0;
            r_operand <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (|w_pending) begin
                        r_code    <= op_e'(w_winner);
                        r_grant   <= w_winner;
                        r_operand <= w_issue_operand;
                        r_valid   <= 1'b1;
                        r_state   <= S_ISSUE;
                    end else begin
                        r_valid <= 1'b0;
                    end
                end
                S_ISSUE: begin
                    if (op.op_ready) begin
                        r_valid <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    always_comb begin
        w_drop_sum = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_drop_sum = w_drop_sum + c_SUM_W'(w_drop[i]);
        end
    end

    // Extra MSB detects overflow so the count can saturate at all-ones.
    assign w_drop_ext = {1'b0, r_drop_count} + c_DROP_X'(w_drop_sum);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_drop_count <= '0;
        end else if (w_drop_ext[DROP_W]) begin
            r_drop_count <= '1;
        end else begin
            r_drop_count <= w_drop_ext[DROP_W-1:0];
        end
    end

    assign op.op_valid   = r_valid;
    assign op.op_code    = r_code;
    assign op.op_operand = r_operand;
    assign busy          = (r_state != S_IDLE) | (|w_pending);
    assign pending       = w_pending;
    assign drop_count    = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_count_cmd_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_count_cmd_scheduler
// Brief   : Directed and randomized bench for count_cmd_scheduler against a
//           behavioural command-queue model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_count_cmd_scheduler;
    import count_ctrl_pkg::*;

    localparam int WIDTH  = 16;
    localparam int DROP_W = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [3:0]        req;
    logic [WIDTH-1:0]  sw;
    logic              ready;
    logic              busy;
    logic [3:0]        pending;
    logic [DROP_W-1:0] drop_count;

    always #5 clk = ~clk;

    count_cmd_scheduler_if #(.WIDTH(WIDTH)) bus ();
    assign bus.op_ready = ready;

    count_cmd_scheduler #(.WIDTH(WIDTH), .DROP_W(DROP_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .sw         (sw),
        .op         (bus),
        .busy       (busy),
        .pending    (pending),
        .drop_count (drop_count)
    );

    int errors = 0;
    int checks = 0;
    int acc[$];

    // Behavioural model: set of outstanding commands plus the one on the wire
    bit   [3:0]       m_pend;
    bit   [3:0]       m_req_d;
    logic [WIDTH-1:0] m_opnd [4];
    bit               m_valid;
    int               m_code;
    logic [WIDTH-1:0] m_operand;
    int               m_drop;
    int               m_rp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit [3:0]         old_pend;
        logic [WIDTH-1:0] old_opnd [4];
        bit               accept;
        int               drops;
        int               start;
        int               win;
        if (!rst_n) begin
            m_pend = '0; m_req_d = '0; m_valid = 0; m_code = 0;
            m_operand = '0; m_drop = 0; m_rp = 0;
            for (int i = 0; i < 4; i++) m_opnd[i] = '0;
            return;
        end
        old_pend = m_pend;
        for (int i = 0; i < 4; i++) old_opnd[i] = m_opnd[i];
        accept = m_valid && ready;
        drops  = 0;
        for (int i = 0; i < 4; i++) begin
            bit rise;
            bit cleared;
            rise    = req[i] && !m_req_d[i];
            cleared = accept && (m_code == i);
            if (rise) begin
                if (m_pend[i] && !cleared) drops++;
                else begin
                    m_pend[i] = 1'b1;
                    if (i >= 2) m_opnd[i] = sw;
                end
            end else if (cleared) begin
                m_pend[i] = 1'b0;
            end
        end
        m_drop  = (m_drop + drops > 255) ? 255 : m_drop + drops;
        m_req_d = req;
        if (m_valid) begin
            if (ready) begin
                m_valid = 0;
                m_rp    = (m_code + 1) % 4;
            end
        end else if (old_pend != 0) begin
`ifdef ROUND_ROBIN_EN
            start = m_rp;
`else
            start = 0;
`endif
            win = -1;
            for (int k = 0; k < 4; k++) begin
                if (win < 0 && old_pend[(start + k) % 4]) win = (start + k) % 4;
            end
            m_valid   = 1;
            m_code    = win;
            m_operand = (win < 2) ? WIDTH'(1) : old_opnd[win];
        end
    endtask

    task automatic compare();
        chk("op_valid", 32'(bus.op_valid), 32'(m_valid));
        chk("busy", 32'(busy), 32'(m_valid || (m_pend != 0)));
        chk("pending", 32'(pending), 32'(m_pend));
        chk("drop_count", 32'(drop_count), 32'(m_drop));
        if (m_valid) begin
            chk("op_code", 32'(bus.op_code), 32'(m_code));
            chk("op_operand", 32'(bus.op_operand), 32'(m_operand));
        end
    endtask

    task automatic tick();
        if (bus.op_valid && ready && rst_n) acc.push_back(int'(bus.op_code));
        @(posedge clk);
        model_step();
        #1;
        compare();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int first;
        rst_n = 1'b0; req = 4'hF; sw = '0; ready = 1'b1;

        // Reset with all requests held high
        run(2);
        chk("rst_pending", 32'(pending), 32'h0);
        chk("rst_valid", 32'(bus.op_valid), 32'h0);
        chk("rst_code", 32'(bus.op_code), 32'h0);
        chk("rst_operand", 32'(bus.op_operand), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_drop", 32'(drop_count), 32'h0);
        rst_n = 1'b1;
        acc.delete();
        tick();
        chk("release_pending", 32'(pending), 32'hF);
        run(10);
        chk("release_count", 32'(acc.size()), 32'd4);
        for (int k = 0; k < 4 && k < acc.size(); k++) chk("release_order", 32'(acc[k]), 32'(k));
        req = 4'h0;
        run(2);

        // Single INC with ready high
        req = 4'h1;
        tick();
        chk("inc_pending", 32'(pending), 32'h1);
        req = 4'h0;
        tick();
        chk("inc_valid", 32'(bus.op_valid), 32'h1);
        chk("inc_code", 32'(bus.op_code), 32'h0);
        chk("inc_operand", 32'(bus.op_operand), 32'h1);
        tick();
        chk("inc_done_pending", 32'(pending), 32'h0);
        chk("inc_done_valid", 32'(bus.op_valid), 32'h0);

        // All four at once, after an INC accept
        acc.delete();
        req = 4'hF;
        tick();
        req = 4'h0;
        run(10);
`ifdef ROUND_ROBIN_EN
        first = 1;
`else
        first = 0;
`endif
        chk("simul_count", 32'(acc.size()), 32'd4);
        for (int k = 0; k < 4 && k < acc.size(); k++) chk("simul_order", 32'(acc[k]), 32'((k + first) % 4));

        // ADD with backpressure and operand change after press
        ready = 1'b0; sw = 16'h0025; req = 4'h4;
        tick();
        req = 4'h0; sw = 16'hFFFF;
        tick();
        chk("add_valid", 32'(bus.op_valid), 32'h1);
        chk("add_code", 32'(bus.op_code), 32'h2);
        chk("add_operand", 32'(bus.op_operand), 32'h25);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("add_hold_valid", 32'(bus.op_valid), 32'h1);
            chk("add_hold_operand", 32'(bus.op_operand), 32'h25);
        end
        ready = 1'b1;
        acc.delete();
        tick();
        chk("add_accept_valid", 32'(bus.op_valid), 32'h0);
        chk("add_accept_n", 32'(acc.size()), 32'd1);
        if (acc.size() > 0) chk("add_accept_code", 32'(acc[0]), 32'd2);

        // Drop counting: three DEC presses while stalled
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req = 4'h2; tick();
            req = 4'h0; tick();
        end
        chk("drop_two", 32'(drop_count), 32'd2);
        acc.delete();
        ready = 1'b1;
        run(6);
        chk("drop_issue_n", 32'(acc.size()), 32'd1);
        if (acc.size() > 0) chk("drop_issue_code", 32'(acc[0]), 32'd1);

        // Saturation, then reset in the middle of an issue
        ready = 1'b0;
        for (int i = 0; i < 301; i++) begin
            req = 4'h2; tick();
            req = 4'h0; tick();
        end
        chk("drop_sat", 32'(drop_count), 32'hFF);
        chk("midrst_pre_valid", 32'(bus.op_valid), 32'h1);
        rst_n = 1'b0;
        tick();
        chk("midrst_valid", 32'(bus.op_valid), 32'h0);
        chk("midrst_pending", 32'(pending), 32'h0);
        chk("midrst_drop", 32'(drop_count), 32'h0);
        rst_n = 1'b1; ready = 1'b1;
        acc.delete();
        run(5);
        chk("midrst_no_reissue", 32'(acc.size()), 32'd0);
        chk("midrst_idle", 32'(busy), 32'h0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 4; i++) if ($urandom_range(0, 3) == 0) req[i] = ~req[i];
            sw    = WIDTH'($urandom);
            ready = ($urandom_range(0, 3) != 0);
            rst_n = ($urandom_range(0, 299) != 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
